vjtag_reg_bank: RTL
===================

VJTAG_REG_BANK -- requirements
Module: vjtag_reg_bank

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, default 64, width of every data register.
- N_RD, default 3, number of read-only registers.
- N_WR, default 5, number of write registers.
- IR_W, default 4, instruction width.
- ID_VALUE, default 32'h0012_3456 zero-extended to DATA_W, constant returned by the ID instruction.
REQ-002 The block SHALL only elaborate when N_RD+N_WR+2 <= 2**IR_W and DATA_W >= 2.
REQ-003 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tdi  in  1  serial data in.
- tdo  out  1  serial data out.
- ir_in  in  IR_W  current instruction.
- st_cdr  in  1  capture-DR qualifier.
- st_sdr  in  1  shift-DR qualifier.
- st_udr  in  1  update-DR qualifier.
- rd_data  in  N_RD*DATA_W  read registers; register k at bits [k*DATA_W +: DATA_W].
- wr_data  out  N_WR*DATA_W  write registers, same packing.
- wr_strobe  out  N_WR  one-cycle commit pulse per write register.
- wr_err  out  1  sticky framing error.
- err_clr  in  1  clears wr_err.

Function
REQ-004 Qualifiers SHALL be sampled on rising clk only; each asserted cycle counts as one TAP event.
REQ-005 The instruction map SHALL be:
- 0: BYPASS.
- 1..N_RD: read register ir_in-1.
- N_RD+1..N_RD+N_WR: write register ir_in-N_RD-1.
- all-ones: ID.
- any other code: BYPASS.
REQ-006 There SHALL be one shared DATA_W shift register (SR), a 1-bit bypass register (BR), and a bit counter (CNT) of width clog2(DATA_W+2) that saturates at DATA_W+1.
REQ-007 The FSM SHALL have two states, IDLE and SHIFT:
- From IDLE, st_cdr goes to SHIFT.
- In SHIFT, st_sdr stays in SHIFT.
- In SHIFT, st_udr returns to IDLE.
- st_cdr while in SHIFT restarts the capture.
REQ-008 On st_cdr, SR SHALL load from the selected source, CNT SHALL clear to 0, and the current ir_in SHALL be latched as IR_L:
- read register: the rd_data slice;
- write register: its current wr_data slice, for readback;
- ID: ID_VALUE;
- BYPASS: BR loads 0 and SR is unchanged.
REQ-009 On st_sdr in SHIFT, SR SHALL become {tdi, SR[DATA_W-1:1]}, BR SHALL become tdi, and CNT SHALL increment with saturation.
REQ-010 tdo SHALL equal SR[0] when IR_L selects a data register or ID, and BR otherwise, driven combinationally from registers.
REQ-011 On st_udr in SHIFT with IR_L selecting write register k:
- If CNT == DATA_W: wr_data slice k <= SR, and wr_strobe[k] is high for exactly the next cycle.
- If CNT != DATA_W: no commit, no strobe, wr_err <= 1.
REQ-012 st_udr with a non-write IR_L, or st_udr in IDLE, SHALL have no effect on outputs.
REQ-013 If ir_in differs from IR_L while in SHIFT, the FSM SHALL go to IDLE with no commit; if IR_L was a write register, wr_err SHALL be set.
REQ-014 Qualifier priority within one cycle SHALL be st_cdr > st_udr > st_sdr; lower-priority qualifiers in the same cycle are ignored.
REQ-015 err_clr SHALL clear wr_err, except that a same-cycle error set SHALL win.
REQ-016 Slices of wr_data SHALL only change on a successful commit; at most one wr_strobe bit SHALL be high in any cycle.
REQ-017 rd_data SHALL be sampled only at capture; later changes SHALL not affect the bits being shifted out.

Reset
REQ-018 While rst_n is low, regardless of clk, these SHALL be held at zero: wr_data, wr_strobe, wr_err, SR, BR, CNT and IR_L; the state SHALL be IDLE, so tdo = 0.
REQ-019 Reset asserted mid-shift SHALL abort the transfer with no commit and no strobe after release.
REQ-020 After rst_n deasserts, the first rising clk SHALL already process qualifiers.

Verification
REQ-021 Write commit: ir_in=4, cdr, 64 sdr shifting 64'hDEAD_BEEF_0123_4567 LSB-first, udr -> wr_data[63:0]=64'hDEAD_BEEF_0123_4567, wr_strobe=5'b00001 for one cycle, wr_err=0.
REQ-022 Short shift: ir_in=5, cdr, 63 sdr, udr -> wr_data slice 1 unchanged (0), no strobe, wr_err=1; err_clr pulse -> wr_err=0.
REQ-023 Read capture: rd_data slice 2 = 64'h0000_0000_CAFE_F00D, ir_in=3, cdr, then rd_data changed to 0, 64 sdr -> tdo yields 64'h0000_0000_CAFE_F00D LSB-first.
REQ-024 ID and bypass:
- ir_in=4'hF, cdr, 32 sdr -> tdo yields 32'h0012_3456.
- ir_in=0, cdr, then sdr with tdi=1,0,1 -> tdo shows 0,1,0.
REQ-025 Abort paths:
- ir_in changed from 6 to 1 after 10 sdr -> FSM to IDLE, wr_err=1, no strobe.
- rst_n low after 40 sdr of a write -> all outputs 0, no strobe after release.
REQ-026 Priority: cdr and udr in the same cycle on ir_in=4 after a full 64-bit shift -> capture only, no commit, CNT=0.

Source files
------------

// File: rtl/vjtag_reg_bank.sv
// ---------------------------------------------------------------------------
// vjtag_reg_bank
//   Register bank behind a virtual-JTAG data path. A single shared shift
//   register serves the read registers, the write registers (with readback)
//   and a constant ID word. A 1-bit bypass register covers unmapped codes.
//   Write registers commit only on a full-length shift. A short shift, or an
//   instruction change mid-transfer, sets a sticky error flag.
//
// Ports
//   clk        clock; all qualifiers are sampled on its rising edge
//   rst_n      asynchronous active-low reset
//   tdi / tdo  serial data in / out (LSB first)
//   ir_in      current instruction
//   st_cdr     capture-DR qualifier
//   st_sdr     shift-DR qualifier
//   st_udr     update-DR qualifier
//   rd_data    read registers, register k at [k*DATA_W +: DATA_W]
//   wr_data    write registers, same packing
//   wr_strobe  one-cycle commit pulse per write register
//   wr_err     sticky framing error
//   err_clr    clears wr_err; a same-cycle error set wins
//
// Instruction map
//   0                       BYPASS
//   1 .. N_RD               read register  (ir - 1)
//   N_RD+1 .. N_RD+N_WR     write register (ir - N_RD - 1)
//   all ones                ID
//   anything else           BYPASS
//
// FSM states
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | no transfer open; sdr/udr are ignored
//   ST_SHIFT  | captured; sdr shifts, udr closes (and commits if valid)
// ---------------------------------------------------------------------------
module vjtag_reg_bank #(
   parameter int                DATA_W   = 64,
   parameter int                N_RD     = 3,
   parameter int                N_WR     = 5,
   parameter int                IR_W     = 4,
   parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(32'h0012_3456)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tdi,
   output logic                     tdo,
   input  logic [IR_W-1:0]          ir_in,
   input  logic                     st_cdr,
   input  logic                     st_sdr,
   input  logic                     st_udr,
   input  logic [N_RD*DATA_W-1:0]   rd_data,
   output logic [N_WR*DATA_W-1:0]   wr_data,
   output logic [N_WR-1:0]          wr_strobe,
   output logic                     wr_err,
   input  logic                     err_clr
);

   generate
      if ((N_RD + N_WR + 2) > (2 ** IR_W) || DATA_W < 2) begin : g_bad_cfg
         $error("vjtag_reg_bank: instruction space too small or DATA_W < 2");
      end
   endgenerate

   localparam int               CNT_W    = $clog2(DATA_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   state_e                  state_q,     state_d;
   logic [DATA_W-1:0]       sr_q,        sr_d;
   logic                    br_q,        br_d;
   logic [CNT_W-1:0]        cnt_q,       cnt_d;
   logic [IR_W-1:0]         ir_l_q,      ir_l_d;
   logic [N_WR*DATA_W-1:0]  wr_data_q,   wr_data_d;
   logic [N_WR-1:0]         wr_strobe_q, wr_strobe_d;
   logic                    wr_err_q,    wr_err_d;
   logic                    err_set;

   function automatic logic is_rd(input logic [IR_W-1:0] code);
      return (int'(code) >= 1) && (int'(code) <= N_RD);
   endfunction

   function automatic logic is_wr(input logic [IR_W-1:0] code);
      return (int'(code) >= N_RD + 1) && (int'(code) <= N_RD + N_WR);
   endfunction

   function automatic logic is_id(input logic [IR_W-1:0] code);
      return &code;
   endfunction

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      br_d        = br_q;
      cnt_d       = cnt_q;
      ir_l_d      = ir_l_q;
      wr_data_d   = wr_data_q;
      wr_strobe_d = '0;
      err_set     = 1'b0;

      if (st_cdr) begin
         // Capture wins over everything else in the cycle, in either state.
         state_d = ST_SHIFT;
         cnt_d   = '0;
         ir_l_d  = ir_in;
         if (is_id(ir_in)) begin
            sr_d = ID_VALUE;
         end else if (is_rd(ir_in)) begin
            for (int k = 0; k < N_RD; k++) begin
               if (int'(ir_in) == k + 1) sr_d = rd_data[k*DATA_W +: DATA_W];
            end
         end else if (is_wr(ir_in)) begin
            for (int k = 0; k < N_WR; k++) begin
               if (int'(ir_in) == N_RD + 1 + k) sr_d = wr_data_q[k*DATA_W +: DATA_W];
            end
         end else begin
            br_d = 1'b0;
         end
      end else if (state_q == ST_SHIFT) begin
         if (ir_in != ir_l_q) begin
            // Instruction changed under an open transfer: drop it.
            state_d = ST_IDLE;
            err_set = is_wr(ir_l_q);
         end else if (st_udr) begin
            state_d = ST_IDLE;
            if (is_wr(ir_l_q)) begin
               if (cnt_q == CNT_FULL) begin
                  for (int k = 0; k < N_WR; k++) begin
                     if (int'(ir_l_q) == N_RD + 1 + k) begin
                        wr_data_d[k*DATA_W +: DATA_W] = sr_q;
                        wr_strobe_d[k]                = 1'b1;
                     end
                  end
               end else begin
                  err_set = 1'b1;
               end
            end
         end else if (st_sdr) begin
            sr_d = {tdi, sr_q[DATA_W-1:1]};
            br_d = tdi;
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
         end
      end

      wr_err_d = err_set | (wr_err_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sr_q        <= '0;
         br_q        <= 1'b0;
         cnt_q       <= '0;
         ir_l_q      <= '0;
         wr_data_q   <= '0;
         wr_strobe_q <= '0;
         wr_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         br_q        <= br_d;
         cnt_q       <= cnt_d;
         ir_l_q      <= ir_l_d;
         wr_data_q   <= wr_data_d;
         wr_strobe_q <= wr_strobe_d;
         wr_err_q    <= wr_err_d;
      end
   end

   assign tdo       = (is_rd(ir_l_q) || is_wr(ir_l_q) || is_id(ir_l_q)) ? sr_q[0] : br_q;
   assign wr_data   = wr_data_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_err    = wr_err_q;

endmodule
